// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
//   Shared types for the memory-port arbiter: FSM state encoding, grant
//   encoding and the default data width.
package mem_arb_pkg;

  localparam int DATA_LEN_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT    = 2'd2,
    ST_DELIVER = 2'd3
  } arb_state_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_IFU  = 2'd1,
    GNT_LSU  = 2'd2
  } grant_t;

endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick
//   Combinational winner select between IFU and LSU requests.
//   Build option MEM_ARB_RR_EN:
//     defined   - round-robin on a tie: the master not served last wins
//     undefined - fixed priority, LSU beats IFU
//   A single requester always wins.
// Ports
//   ifu_valid   in   IFU request pending
//   lsu_valid   in   LSU request pending
//   last_grant  in   master served last (only with MEM_ARB_RR_EN)
//   winner      out  selected master, GNT_NONE when nobody requests
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic   ifu_valid,
  input  logic   lsu_valid,
`ifdef MEM_ARB_RR_EN
  input  grant_t last_grant,
`endif
  output grant_t winner
);

  always_comb begin
    winner = GNT_NONE;
    if (ifu_valid && lsu_valid) begin
`ifdef MEM_ARB_RR_EN
      winner = (last_grant == GNT_LSU) ? GNT_IFU : GNT_LSU;
`else
      winner = GNT_LSU;
`endif
    end else if (lsu_valid) begin
      winner = GNT_LSU;
    end else if (ifu_valid) begin
      winner = GNT_IFU;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares the single memory port between IFU (fetch, read-only) and LSU
//   (load/store). One transaction outstanding; the response goes back only
//   to the master that issued it. Optional round-robin tie-break with
//   MEM_ARB_RR_EN (see mem_arb_pick).
// Ports
//   clk, rst_n                   clock, synchronous active-low reset
//   ifu_req_* / ifu_rsp_*        IFU request (valid/ready/addr) and response
//   lsu_req_* / lsu_rsp_*        LSU request (valid/ready/wen/addr/wdata/wstrb)
//                                and response
//   mem_req_* / mem_rsp_*        memory request (registered payload) and response
//
// state       | meaning
// ------------+--------------------------------------------------------
// ST_IDLE     | no transaction; winner gets req_ready and payload latched
// ST_ISSUE    | mem_req_valid with latched payload until mem_req_ready
// ST_WAIT     | mem_rsp_ready; capture read data on mem_rsp_valid
// ST_DELIVER  | granted master's rsp_valid until its rsp_ready
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_LEN = DATA_LEN_DEF,
  parameter int STRB_LEN = DATA_LEN / 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ifu_req_valid,
  output logic                ifu_req_ready,
  input  logic [DATA_LEN-1:0] ifu_req_addr,
  output logic                ifu_rsp_valid,
  input  logic                ifu_rsp_ready,
  output logic [DATA_LEN-1:0] ifu_rsp_rdata,
  input  logic                lsu_req_valid,
  output logic                lsu_req_ready,
  input  logic                lsu_req_wen,
  input  logic [DATA_LEN-1:0] lsu_req_addr,
  input  logic [DATA_LEN-1:0] lsu_req_wdata,
  input  logic [STRB_LEN-1:0] lsu_req_wstrb,
  output logic                lsu_rsp_valid,
  input  logic                lsu_rsp_ready,
  output logic [DATA_LEN-1:0] lsu_rsp_rdata,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic                mem_req_wen,
  output logic [DATA_LEN-1:0] mem_req_addr,
  output logic [DATA_LEN-1:0] mem_req_wdata,
  output logic [STRB_LEN-1:0] mem_req_wstrb,
  input  logic                mem_rsp_valid,
  output logic                mem_rsp_ready,
  input  logic [DATA_LEN-1:0] mem_rsp_rdata
);

  arb_state_t          state_q, state_d;
  grant_t              grant_q, grant_d;
  grant_t              winner;
  logic                accept;
  logic                rsp_take;
  logic                wen_q;
  logic [DATA_LEN-1:0] addr_q, wdata_q, rdata_q;
  logic [STRB_LEN-1:0] wstrb_q;

`ifdef MEM_ARB_RR_EN
  grant_t              last_grant_q;

  // Reset value IFU makes the LSU win the first tie.
  always_ff @(posedge clk) begin
    if (!rst_n)      last_grant_q <= GNT_IFU;
    else if (accept) last_grant_q <= winner;
  end

  mem_arb_pick u_pick (
    .ifu_valid  (ifu_req_valid),
    .lsu_valid  (lsu_req_valid),
    .last_grant (last_grant_q),
    .winner     (winner)
  );
`else
  mem_arb_pick u_pick (
    .ifu_valid  (ifu_req_valid),
    .lsu_valid  (lsu_req_valid),
    .winner     (winner)
  );
`endif

  // req_ready is combinational; gating with rst_n keeps it low while reset
  // is held even though the synchronous reset has not yet reached state_q.
  assign accept        = rst_n && (state_q == ST_IDLE) && (winner != GNT_NONE);
  assign ifu_req_ready = accept && (winner == GNT_IFU);
  assign lsu_req_ready = accept && (winner == GNT_LSU);

  assign mem_req_valid = (state_q == ST_ISSUE);
  assign mem_rsp_ready = (state_q == ST_WAIT);
  assign ifu_rsp_valid = (state_q == ST_DELIVER) && (grant_q == GNT_IFU);
  assign lsu_rsp_valid = (state_q == ST_DELIVER) && (grant_q == GNT_LSU);
  assign rsp_take      = (ifu_rsp_valid && ifu_rsp_ready) || (lsu_rsp_valid && lsu_rsp_ready);

  assign mem_req_wen   = wen_q;
  assign mem_req_addr  = addr_q;
  assign mem_req_wdata = wdata_q;
  assign mem_req_wstrb = wstrb_q;
  assign ifu_rsp_rdata = rdata_q;
  assign lsu_rsp_rdata = rdata_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      grant_q <= GNT_NONE;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_ISSUE;
          grant_d = winner;
        end
      end
      ST_ISSUE:   if (mem_req_ready) state_d = ST_WAIT;
      ST_WAIT:    if (mem_rsp_valid) state_d = ST_DELIVER;
      ST_DELIVER: begin
        if (rsp_take) begin
          state_d = ST_IDLE;
          grant_d = GNT_NONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = GNT_NONE;
      end
    endcase
  end

  // Fetches carry no write data; their write fields are forced to zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wen_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
    end else begin
      if (accept) begin
        if (winner == GNT_LSU) begin
          wen_q   <= lsu_req_wen;
          addr_q  <= lsu_req_addr;
          wdata_q <= lsu_req_wdata;
          wstrb_q <= lsu_req_wstrb;
        end else begin
          wen_q   <= 1'b0;
          addr_q  <= ifu_req_addr;
          wdata_q <= '0;
          wstrb_q <= '0;
        end
      end
      if ((state_q == ST_WAIT) && mem_rsp_valid) rdata_q <= mem_rsp_rdata;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        ifu_req_valid, ifu_req_ready;
  logic [31:0] ifu_req_addr;
  logic        ifu_rsp_valid, ifu_rsp_ready;
  logic [31:0] ifu_rsp_rdata;
  logic        lsu_req_valid, lsu_req_ready, lsu_req_wen;
  logic [31:0] lsu_req_addr, lsu_req_wdata;
  logic [3:0]  lsu_req_wstrb;
  logic        lsu_rsp_valid, lsu_rsp_ready;
  logic [31:0] lsu_rsp_rdata;
  logic        mem_req_valid, mem_req_ready, mem_req_wen;
  logic [31:0] mem_req_addr, mem_req_wdata;
  logic [3:0]  mem_req_wstrb;
  logic        mem_rsp_valid, mem_rsp_ready;
  logic [31:0] mem_rsp_rdata;

  mem_arbiter #(.DATA_LEN(32), .STRB_LEN(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ifu_req_valid (ifu_req_valid),
    .ifu_req_ready (ifu_req_ready),
    .ifu_req_addr  (ifu_req_addr),
    .ifu_rsp_valid (ifu_rsp_valid),
    .ifu_rsp_ready (ifu_rsp_ready),
    .ifu_rsp_rdata (ifu_rsp_rdata),
    .lsu_req_valid (lsu_req_valid),
    .lsu_req_ready (lsu_req_ready),
    .lsu_req_wen   (lsu_req_wen),
    .lsu_req_addr  (lsu_req_addr),
    .lsu_req_wdata (lsu_req_wdata),
    .lsu_req_wstrb (lsu_req_wstrb),
    .lsu_rsp_valid (lsu_rsp_valid),
    .lsu_rsp_ready (lsu_rsp_ready),
    .lsu_rsp_rdata (lsu_rsp_rdata),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_wen   (mem_req_wen),
    .mem_req_addr  (mem_req_addr),
    .mem_req_wdata (mem_req_wdata),
    .mem_req_wstrb (mem_req_wstrb),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_ready (mem_rsp_ready),
    .mem_rsp_rdata (mem_rsp_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          is_lsu;
    bit          wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
    bit          chk_data;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;
  bit   last_lsu = 1'b0;

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Memory contents as the bench's memory model returns them.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h8000_0000) return 32'h0010_0093;
    return a ^ 32'hA5A5_5A5A;
  endfunction

  function automatic bit model_pick_lsu(input bit iv, input bit lv);
`ifdef MEM_ARB_RR_EN
    if (iv && lv) return !last_lsu;
`endif
    return lv;
  endfunction

  // Called at drive time of a cycle where the DUT is IDLE with requests set.
  task automatic accept(input bit drop);
    exp_t e;
    bit   w_lsu;
    w_lsu      = model_pick_lsu(ifu_req_valid, lsu_req_valid);
    e.is_lsu   = w_lsu;
    e.wen      = w_lsu ? lsu_req_wen : 1'b0;
    e.addr     = w_lsu ? lsu_req_addr : ifu_req_addr;
    e.wdata    = w_lsu ? lsu_req_wdata : 32'h0;
    e.wstrb    = w_lsu ? lsu_req_wstrb : 4'h0;
    e.rdata    = mem_word(e.addr);
    e.chk_data = !e.wen;
    sb_q.push_back(e);
    last_lsu = w_lsu;
    @(negedge clk);
    chk1("ifu_req_ready", ifu_req_ready, !w_lsu);
    chk1("lsu_req_ready", lsu_req_ready, w_lsu);
    chk1("idle_rsp_valid", ifu_rsp_valid | lsu_rsp_valid, 1'b0);
    @(posedge clk); #1;
    if (drop) begin
      if (w_lsu) lsu_req_valid = 1'b0;
      else       ifu_req_valid = 1'b0;
    end
  endtask

  // Called at drive time of the first ISSUE cycle.
  task automatic mem_serve(input int stall, input bit stray);
    exp_t e;
    if (sb_q.size() == 0) begin
      chk1("sb_nonempty_serve", 1'b0, 1'b1);
      return;
    end
    e = sb_q[$];
    for (int i = 0; i <= stall; i++) begin
      mem_req_ready = (i == stall);
      mem_rsp_valid = stray && (i < stall);
      mem_rsp_rdata = 32'hBAD0_BAD0;
      @(negedge clk);
      chk1("mem_req_valid", mem_req_valid, 1'b1);
      chk1("mem_req_wen", mem_req_wen, e.wen);
      chk32("mem_req_addr", mem_req_addr, e.addr);
      chk32("mem_req_wdata", mem_req_wdata, e.wdata);
      chk32("mem_req_wstrb", 32'(mem_req_wstrb), 32'(e.wstrb));
      chk1("issue_rsp_ready", mem_rsp_ready, 1'b0);
      chk1("busy_req_ready", ifu_req_ready | lsu_req_ready, 1'b0);
      @(posedge clk); #1;
    end
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rsp_rdata = mem_word(e.addr);
    @(negedge clk);
    chk1("wait_no_reissue", mem_req_valid, 1'b0);
    chk1("wait_rsp_ready", mem_rsp_ready, 1'b1);
    @(posedge clk); #1;
    mem_rsp_valid = 1'b0;
    mem_rsp_rdata = 32'hFFFF_0000;
  endtask

  // Called at drive time of the first DELIVER cycle.
  task automatic deliver(input int stall);
    exp_t e;
    if (sb_q.size() == 0) begin
      chk1("sb_nonempty_deliver", 1'b0, 1'b1);
      return;
    end
    e = sb_q[0];
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk1("rsp_valid_hold", e.is_lsu ? lsu_rsp_valid : ifu_rsp_valid, 1'b1);
      chk1("rsp_other_low", e.is_lsu ? ifu_rsp_valid : lsu_rsp_valid, 1'b0);
      if (e.chk_data) chk32("rdata_hold", e.is_lsu ? lsu_rsp_rdata : ifu_rsp_rdata, e.rdata);
      @(posedge clk); #1;
    end
    ifu_rsp_ready = 1'b1;
    lsu_rsp_ready = 1'b1;
    @(negedge clk);
    e = sb_q.pop_front();
    chk1("ifu_rsp_valid", ifu_rsp_valid, !e.is_lsu);
    chk1("lsu_rsp_valid", lsu_rsp_valid, e.is_lsu);
    chk1("deliver_mem_idle", mem_req_valid | mem_rsp_ready, 1'b0);
    if (e.chk_data) chk32("rsp_rdata", e.is_lsu ? lsu_rsp_rdata : ifu_rsp_rdata, e.rdata);
    @(posedge clk); #1;
    ifu_rsp_ready = 1'b0;
    lsu_rsp_ready = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    ifu_req_valid = 1'b1; ifu_req_addr = 32'h0;
    ifu_rsp_ready = 1'b0;
    lsu_req_valid = 1'b1; lsu_req_wen = 1'b0; lsu_req_addr = 32'h0;
    lsu_req_wdata = 32'h0; lsu_req_wstrb = 4'h0; lsu_rsp_ready = 1'b0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_rdata = 32'h0;

    // Reset state, requests pending while reset is held
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    chk1("rst_ifu_req_ready", ifu_req_ready, 1'b0);
    chk1("rst_lsu_req_ready", lsu_req_ready, 1'b0);
    chk1("rst_mem_req_valid", mem_req_valid, 1'b0);
    chk1("rst_mem_rsp_ready", mem_rsp_ready, 1'b0);
    chk1("rst_rsp_valid", ifu_rsp_valid | lsu_rsp_valid, 1'b0);
    chk32("rst_mem_req_addr", mem_req_addr, 32'h0);
    chk32("rst_mem_req_wdata", mem_req_wdata, 32'h0);
    chk1("rst_mem_req_wen", mem_req_wen, 1'b0);
    @(posedge clk); #1;
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: IFU alone, minimum round trip
    ifu_req_valid = 1'b1; ifu_req_addr = 32'h8000_0000;
    accept(1'b1);
    mem_serve(0, 1'b0);
    deliver(0);

    // 2: both valid, LSU load first, then IFU in the next IDLE
    ifu_req_valid = 1'b1; ifu_req_addr = 32'h8000_0004;
    lsu_req_valid = 1'b1; lsu_req_wen = 1'b0; lsu_req_addr = 32'h8000_1000;
    lsu_req_wdata = 32'h1111_2222; lsu_req_wstrb = 4'hF;
    accept(1'b1);
    mem_serve(0, 1'b0);
    deliver(1);
    accept(1'b1);
    mem_serve(0, 1'b0);
    deliver(0);

    // 3: LSU store, exact payload and ack
    lsu_req_valid = 1'b1; lsu_req_wen = 1'b1; lsu_req_addr = 32'h8000_2000;
    lsu_req_wdata = 32'hDEAD_BEEF; lsu_req_wstrb = 4'b0011;
    accept(1'b1);
    mem_serve(0, 1'b0);
    deliver(0);

    // 4: memory stalls 5 cycles (stray responses meanwhile), IFU stalls 3
    ifu_req_valid = 1'b1; ifu_req_addr = 32'h8000_0010;
    accept(1'b1);
    mem_serve(5, 1'b1);
    deliver(3);

    // 5: reset while waiting for memory, then stray memory responses
    ifu_req_valid = 1'b1; ifu_req_addr = 32'h8000_0040;
    accept(1'b1);
    mem_req_ready = 1'b1;
    @(negedge clk);
    chk1("t5_mem_req_valid", mem_req_valid, 1'b1);
    @(posedge clk); #1;
    mem_req_ready = 1'b0;
    @(negedge clk);
    chk1("t5_in_wait", mem_rsp_ready, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b0; ifu_req_valid = 1'b1;
    mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'h1234_5678;
    @(negedge clk);
    chk1("t5_rst_req_ready", ifu_req_ready, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1; ifu_req_valid = 1'b0;
    sb_q.delete();
    last_lsu = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk1("t5_ifu_rsp_valid", ifu_rsp_valid, 1'b0);
      chk1("t5_lsu_rsp_valid", lsu_rsp_valid, 1'b0);
      chk1("t5_mem_rsp_ready", mem_rsp_ready, 1'b0);
      chk1("t5_mem_req_valid", mem_req_valid, 1'b0);
      @(posedge clk); #1;
    end
    mem_rsp_valid = 1'b0;

    // 6: both valid for four back-to-back transactions
    ifu_req_valid = 1'b1; ifu_req_addr = 32'h8000_0100;
    lsu_req_valid = 1'b1; lsu_req_wen = 1'b0; lsu_req_addr = 32'h8000_3000;
    lsu_req_wdata = 32'h0; lsu_req_wstrb = 4'h0;
    for (int k = 0; k < 4; k++) begin
      accept(1'b0);
      if (k == 3) begin
        ifu_req_valid = 1'b0;
        lsu_req_valid = 1'b0;
      end
      mem_serve(0, 1'b0);
      deliver(0);
    end
    @(negedge clk);
    chk1("end_idle_req_valid", mem_req_valid, 1'b0);
    chk32("end_sb_empty", sb_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
